// File: rtl/state_sequencer.sv
// Instruction sequencer: FETCH -> EXEC1 -> EXEC2 -> FETCH, with stall hold and an absorbing HALT.
// Define STATE_SEQUENCER_WATCHDOG_EN to add a consecutive-stall watchdog that forces HALT.
// state_o encoding: 2'd0 FETCH, 2'd1 EXEC1, 2'd2 EXEC2, 2'd3 HALT.
module state_sequencer #(
    parameter int unsigned WATCHDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_access_i,
    input  logic        waitrequest_i,
    input  logic        muldiv_busy_i,
    input  logic        halt_i,
    output logic [1:0]  state_o,
    output logic        advance_o,
    output logic        stall_o,
    output logic        active_o,
    output logic [31:0] retired_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        HALT  = 2'd3
    } state_t;

    if (WATCHDOG_LIMIT < 2 || WATCHDOG_LIMIT > 65535) begin : g_bad_limit
        $error("state_sequencer: WATCHDOG_LIMIT must be in 2..65535");
    end

    state_t      r_state;
    logic [31:0] r_retired;
    logic        r_active;
    logic        w_stall;
    logic        w_advance;

    // muldiv_busy_i only matters in EXEC2; nothing stalls once halted.
    assign w_stall   = (r_state != HALT) &&
                       ((ram_access_i && waitrequest_i) || (r_state == EXEC2 && muldiv_busy_i));
    assign w_advance = (r_state != HALT) && !w_stall;

`ifdef STATE_SEQUENCER_WATCHDOG_EN
    localparam logic [15:0] WD_LIMIT = 16'(WATCHDOG_LIMIT);

    logic [15:0] r_wd_cnt;
    logic        r_timeout;
    logic [15:0] w_wd_next;
    logic        w_wd_fire;

    assign w_wd_next = r_wd_cnt + 16'd1;
    assign w_wd_fire = w_stall && (w_wd_next == WD_LIMIT);
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= FETCH;
            r_retired <= 32'd0;
            r_active  <= 1'b1;
`ifdef STATE_SEQUENCER_WATCHDOG_EN
            r_wd_cnt  <= 16'd0;
            r_timeout <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (w_advance) r_state <= EXEC1;
                end
                EXEC1: begin
                    if (w_advance) r_state <= EXEC2;
                end
                EXEC2: begin
                    if (w_advance) begin
                        r_retired <= r_retired + 32'd1;
                        if (halt_i) begin
                            r_state  <= HALT;
                            r_active <= 1'b0;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
            endcase
`ifdef STATE_SEQUENCER_WATCHDOG_EN
            if (w_stall) r_wd_cnt <= w_wd_next;
            else         r_wd_cnt <= 16'd0;
            // Overrides the hold above; a stalled cycle never retires, so retired_o is untouched.
            if (w_wd_fire) begin
                r_state   <= HALT;
                r_active  <= 1'b0;
                r_timeout <= 1'b1;
            end
`endif
        end
    end

    assign state_o   = r_state;
    assign advance_o = w_advance;
    assign stall_o   = w_stall;
    assign active_o  = r_active;
    assign retired_o = r_retired;

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 SHALL have parameter WATCHDOG_LIMIT, default 1024: consecutive stall cycles before forced halt (range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ram_access_i  input  1  control block is asserting ram read or write enable this cycle.
REQ-005 SHALL have port waitrequest_i  input  1  memory bus not ready; current access must be held.
REQ-006 SHALL have port muldiv_busy_i  input  1  multiply/divide unit still computing.
REQ-007 SHALL have port halt_i  input  1  current instruction is a jump to address 0 (end of program).
REQ-008 SHALL have port state_o  output  state_t  current state: FETCH, EXEC1, EXEC2 or HALT.
REQ-009 SHALL have port advance_o  output  1  state leaves current state at next edge; gates pc/ir/regfile write enables.
REQ-010 SHALL have port stall_o  output  1  current state held this cycle.
REQ-011 SHALL have port active_o  output  1  high unless state is HALT.
REQ-012 SHALL have port retired_o  output  32  count of completed instructions.
REQ-013 SHALL have port timeout_o  output  1  sticky flag, watchdog forced halt.

Function
REQ-014 stall_o SHALL equal (ram_access_i AND waitrequest_i) OR (state_o==EXEC2 AND muldiv_busy_i); forced 0 in HALT.
REQ-015 muldiv_busy_i SHALL be ignored in FETCH, EXEC1 and HALT.
REQ-016 advance_o SHALL equal NOT stall_o in FETCH/EXEC1/EXEC2, and 0 in HALT; combinational, same cycle.
REQ-017 Transitions on advance: FETCH->EXEC1, EXEC1->EXEC2, EXEC2->FETCH, except EXEC2->HALT when halt_i=1.
REQ-018 On stall the state SHALL be held; halt_i sampled only on the EXEC2 cycle where advance_o=1 (stall wins over halt).
REQ-019 HALT SHALL be absorbing until reset; halt_i and all other inputs ignored there.
REQ-020 retired_o SHALL increment by 1 on every EXEC2 advance, including the EXEC2->HALT advance; wraps 0xFFFFFFFF->0.
REQ-021 Each FETCH->EXEC2 sequence with no stalls SHALL take exactly 3 cycles; each stall cycle adds exactly 1.

Reset
REQ-022 Asserting reset SHALL immediately, without a clock edge, set state_o=FETCH, retired_o=0, timeout_o=0, watchdog count=0.
REQ-023 Reset mid-stall or mid-instruction SHALL abandon the instruction with no retire increment.
REQ-024 First cycle after reset release SHALL be FETCH with normal stall evaluation.

Configuration
REQ-025 Macro STATE_SEQUENCER_WATCHDOG_EN SHALL enable a 16-bit consecutive-stall counter, cleared on any non-stall cycle.
REQ-026 With the macro, the stall cycle on which the counter reaches WATCHDOG_LIMIT SHALL cause next state HALT and timeout_o=1 (sticky); retired_o unchanged.
REQ-027 Without the macro, no counter SHALL exist, timeout_o SHALL be constant 0, and stalls SHALL hold indefinitely.

Verification
REQ-028 Release reset, all inputs 0, 9 cycles -> state F,E1,E2 x3, advance_o=1 every cycle, retired_o=3.
REQ-029 FETCH with ram_access_i=1, waitrequest_i=1 for 4 cycles -> FETCH held 4 cycles, stall_o=1, advance_o=0, then EXEC1.
REQ-030 muldiv_busy_i=1 across EXEC1 and 3 EXEC2 cycles -> EXEC1 not held, EXEC2 held 3 cycles, then FETCH, retired_o+1.
REQ-031 halt_i=1 in EXEC2 with no stall -> HALT next cycle, active_o=0, retired_o+1, unchanged over 10 further cycles with random inputs.
REQ-032 Macro defined, WATCHDOG_LIMIT=8, waitrequest_i stuck 1 in FETCH -> HALT after 8 stall cycles, timeout_o=1; macro undefined -> FETCH held 100 cycles, timeout_o=0.
REQ-033 reset pulsed between clock edges during EXEC1 stall with retired_o=5 -> state_o=FETCH and retired_o=0 before next edge.
